// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and helpers for the token-ring round-robin arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ring_arb_pkg;

  // Arbiter control states: IDLE means no owner, GRANT means one requester owns the resource.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of a requester index; kept at least 1 bit so a port never collapses.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Rotate the low n bits of a one-hot vector left by one, wrapping bit n-1 to bit 0.
  // A fixed 16-bit carrier covers every legal requester count.
  function automatic logic [15:0] rotl1(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r[4'((i + 1) % n)] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the ring arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; requesters hold req until they see their grant.
interface ring_rr_arbiter_if #(
  parameter int N = 4
);
  import ring_arb_pkg::*;

  localparam int IW = id_width(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic [N-1:0]  token;

  // Requester side drives requests and observes the grant state.
  modport master (
    output req,
    input  grant, grant_valid, grant_id, token
  );

  // Arbiter side consumes requests and publishes the grant state.
  modport slave (
    input  req,
    output grant, grant_valid, grant_id, token
  );

endinterface

// File: rtl/ring_rr_arbiter_pick.sv
// Combinational winner search: first set req bit at or above the token, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; winner is all zeros when no request is set.
module ring_rr_pick
  import ring_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  token,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_id
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic           found;

  // Lower half keeps only requests at/above the token; upper half is the unmasked
  // copy, so scanning upward from bit 0 wraps naturally past requester N-1.
  always_comb begin
    mask   = ~(token - N'(1));
    dbl    = {req, req & mask};
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && dbl[i]) begin
        found  = 1'b1;
        win_id = IW'(i % N);
      end
    end
    win_oh = found ? (N'(1) << win_id) : '0;
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot token ring and a per-win burst limit.
// Latency: grant registered at the same edge the request is sampled in IDLE.
// Backpressure: owner keeps the grant while it requests, up to MAX_HOLD cycles; one dead cycle between grants.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  ring_rr_arbiter_if.slave bus
);

  localparam int IW = id_width(N);

  arb_state_t    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] id_q, id_d;
  logic [N-1:0]  token_q, token_d;

  logic [N-1:0]  win_oh;
  logic [IW-1:0] win_id;

  ring_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (bus.req),
    .token  (token_q),
    .win_oh (win_oh),
    .win_id (win_id)
  );

  // State, hold counter, grant and token registers; reset aborts any burst outright.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      token_q <= N'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      token_q <= token_d;
    end
  end

  // Next-state logic: arbitrate only from IDLE, so every release leaves one dead cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    id_d    = id_q;
    token_d = token_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          grant_d = win_oh;
          id_d    = win_id;
          cnt_d   = 8'd1;
          token_d = N'(rotl1(16'(win_oh), N));
        end
      end
      GRANT: begin
        if (bus.req[id_q] && (cnt_q < 8'(MAX_HOLD))) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_id    = id_q;
  assign bus.token       = token_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter: table of single-cycle vectors plus burst sequences.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: requests are held by the bench until granted, as the arbiter expects.
module tb_ring_rr_arbiter;
  import ring_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ring_rr_arbiter_if #(.N(4)) bus8 ();
  ring_rr_arbiter_if #(.N(4)) bus1 ();

  ring_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  ring_rr_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] token;
    logic [1:0] id;
  } vec_t;

  vec_t tbl[18];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [3:0] eg, input logic [3:0] et,
                        input logic [1:0] eid);
    logic ev;
    ev = |eg;
    n_vec++;
    if (bus8.grant !== eg || bus8.grant_valid !== ev || bus8.grant_id !== eid ||
        bus8.token !== et) begin
      n_bad++;
      $display("FAIL %s: got grant=%b valid=%b id=%0d token=%b, want grant=%b valid=%b id=%0d token=%b",
               name, bus8.grant, bus8.grant_valid, bus8.grant_id, bus8.token, eg, ev, eid, et);
    end
  endtask

  task automatic check1(input string name, input logic [3:0] eg, input logic [3:0] et,
                        input logic [1:0] eid);
    logic ev;
    ev = |eg;
    n_vec++;
    if (bus1.grant !== eg || bus1.grant_valid !== ev || bus1.grant_id !== eid ||
        bus1.token !== et) begin
      n_bad++;
      $display("FAIL %s: got grant=%b valid=%b id=%0d token=%b, want grant=%b valid=%b id=%0d token=%b",
               name, bus1.grant, bus1.grant_valid, bus1.grant_id, bus1.token, eg, ev, eid, et);
    end
  endtask

  initial begin
    logic [3:0] oh;
    logic [3:0] nx;
    int         w;

    rst      = 1'b0;
    bus8.req = 4'b0000;
    bus1.req = 4'b0000;

    //            rst   req      grant    token    id
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 2'd0};  // reset
    tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0};  // idle x5
    tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0};
    tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd0};
    tbl[6]  = '{1'b1, 4'b0100, 4'b0100, 4'b1000, 2'd2};  // req 2 held 3 cycles
    tbl[7]  = '{1'b1, 4'b0100, 4'b0100, 4'b1000, 2'd2};
    tbl[8]  = '{1'b1, 4'b0100, 4'b0100, 4'b1000, 2'd2};
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b1000, 2'd2};  // voluntary release, id holds
    tbl[10] = '{1'b1, 4'b0011, 4'b0001, 4'b0010, 2'd0};  // search wraps past bit 3
    tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0010, 2'd0};
    tbl[12] = '{1'b1, 4'b0010, 4'b0010, 4'b0100, 2'd1};
    tbl[13] = '{1'b1, 4'b1000, 4'b0000, 4'b0100, 2'd1};  // req1 drops as req3 rises
    tbl[14] = '{1'b1, 4'b1000, 4'b1000, 4'b0001, 2'd3};  // token wraps to 0001
    tbl[15] = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd3};
    tbl[16] = '{1'b1, 4'b1000, 4'b1000, 4'b0001, 2'd3};  // lone requester 3 from token 0
    tbl[17] = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 2'd3};

    for (int i = 0; i < 18; i++) begin
      rst      = tbl[i].rst;
      bus8.req = tbl[i].req;
      tick();
      check8($sformatf("vec%0d", i), tbl[i].grant, tbl[i].token, tbl[i].id);
    end

    // All requesters busy: winners 0,1,2,3,0, each 8 cycles then one idle cycle.
    bus8.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w  = k % 4;
      oh = 4'b0001 << w;
      nx = 4'b0001 << ((w + 1) % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        check8($sformatf("burst%0d_c%0d", k, c), oh, nx, 2'(w));
      end
      tick();
      check8($sformatf("burst%0d_gap", k), 4'b0000, nx, 2'(w));
    end

    // Reset lands mid-burst: grant and token drop straight to their reset values.
    tick();
    check8("pre_rst_grant", 4'b0010, 4'b0100, 2'd1);
    rst = 1'b0;
    tick();
    check8("mid_burst_rst", 4'b0000, 4'b0001, 2'd0);
    rst = 1'b1;
    tick();
    check8("post_rst_grant", 4'b0001, 4'b0010, 2'd0);
    bus8.req = 4'b0000;
    tick();
    check8("post_rst_idle", 4'b0000, 4'b0010, 2'd0);

    // MAX_HOLD = 1: held request alternates one grant cycle with one idle cycle.
    check1("h1_idle", 4'b0000, 4'b0001, 2'd0);
    bus1.req = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      tick();
      check1($sformatf("h1_c%0d", k), (k % 2 == 0) ? 4'b0010 : 4'b0000, 4'b0100, 2'd1);
    end
    bus1.req = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
